async_fifo_wr_arbiter: RTL

Write-side scheduler that shares the single write port of the async FIFO among `NUM_REQ` producers in the write clock domain. Producers use a valid/ready handshake. The block grants the FIFO to one producer at a time in round-robin order, in bursts of up to `MAX_BURST` beats. It drives `wr_en`/`wr_data` so that a write is never issued while `wr_full` is high.

---
 rtl/async_fifo_wr_arbiter_if.sv | 23 ++
 rtl/async_fifo_wr_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the async FIFO write port.
// slave = arbiter view, master = producer/FIFO-side view.
interface async_fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wr_full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;

  modport master (
    output req_valid, req_data, wr_full,
    input  req_ready, wr_en, wr_data
  );

  modport slave (
    input  req_valid, req_data, wr_full,
    output req_ready, wr_en, wr_data
  );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin write-port scheduler for the async FIFO: one producer owns the port
// for a burst of up to MAX_BURST beats, and no write is issued while wr_full is high.
//
//   state | meaning
//   IDLE  | no owner; scan req_valid from rr_ptr and grant the first hit
//   BURST | owner holds the port; beats transfer when owner valid and FIFO not full
module async_fifo_wr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_BURST  = 4,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst_n,
  async_fifo_wr_arbiter_if.slave bus,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic [15:0]            xfer_count
);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] rr_ptr;
  logic [BCW-1:0] beat_cnt;
  logic [IDW-1:0] scan_idx;
  logic           scan_hit;
  logic [IDW-1:0] next_rr;
  logic           owner_valid;
  logic           acc;

  // First valid requester at or after rr_ptr, wrapping; works for non-power-of-two NUM_REQ.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!scan_hit && bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        scan_hit = 1'b1;
        scan_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign owner_valid = bus.req_valid[owner];
  assign acc         = (state == BURST) && owner_valid && !bus.wr_full;
  assign next_rr     = (owner == LAST_ID) ? '0 : owner + 1'b1;

  always_comb begin
    bus.req_ready        = '0;
    bus.req_ready[owner] = acc;
    bus.wr_en            = acc;
    bus.wr_data          = '0;
    if (state == BURST) begin
      bus.wr_data = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_hit) begin
            owner    <= scan_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (acc) begin
            xfer_count <= xfer_count + 16'd1;
            beat_cnt   <= beat_cnt + 1'b1;
          end
          // Final beat or owner withdrew; a full FIFO alone never ends the burst.
          if ((acc && beat_cnt == LAST_BEAT) || !owner_valid) begin
            state  <= IDLE;
            rr_ptr <= next_rr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_id = owner;
  assign busy     = (state == BURST);
endmodule
